// File: rtl/disp_scan_ctrl.sv
// Four-digit display scan controller with a frame-synchronous shadow buffer for the digit data.
// Optional per-digit blinking is built only when DISP_BLINK_EN is defined.
module disp_scan_ctrl #(
   parameter int DIV_W   = 16,
   parameter int BLINK_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] hex_in,
   input  logic [3:0]  point_in,
   input  logic [3:0]  blink_in,
   output logic [1:0]  Scan,
   output logic [15:0] Hexs,
   output logic [3:0]  point,
   output logic [3:0]  LES,
   output logic        pending,
   output logic        frame_tick
);

   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       scan_q, scan_d;
   logic [15:0]      hexs_q, hexs_d;
   logic [3:0]       point_q, point_d;
   logic [15:0]      shadow_hex_q, shadow_hex_d;
   logic [3:0]       shadow_point_q, shadow_point_d;
   logic             pending_q, pending_d;
   logic             tick_q, tick_d;
   logic             slot_end;
   logic             frame_edge;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch can be inferred.
      div_d          = div_q + 1'b1;
      slot_end       = &div_q;
      scan_d         = slot_end ? scan_q + 2'd1 : scan_q;
      frame_edge     = slot_end && (scan_q == 2'd3);
      tick_d         = frame_edge;
      hexs_d         = hexs_q;
      point_d        = point_q;
      shadow_hex_d   = shadow_hex_q;
      shadow_point_d = shadow_point_q;
      pending_d      = pending_q;

      if (frame_edge) begin
         // A load landing on the boundary bypasses the shadow and wins over older pending data.
         if (load) begin
            hexs_d  = hex_in;
            point_d = point_in;
         end else if (pending_q) begin
            hexs_d  = shadow_hex_q;
            point_d = shadow_point_q;
         end
         pending_d = 1'b0;
      end else if (load) begin
         shadow_hex_d   = hex_in;
         shadow_point_d = point_in;
         pending_d      = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q          <= '0;
         scan_q         <= '0;
         hexs_q         <= '0;
         point_q        <= '0;
         shadow_hex_q   <= '0;
         shadow_point_q <= '0;
         pending_q      <= 1'b0;
         tick_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         div_q          <= div_d;
         scan_q         <= scan_d;
         hexs_q         <= hexs_d;
         point_q        <= point_d;
         shadow_hex_q   <= shadow_hex_d;
         shadow_point_q <= shadow_point_d;
         pending_q      <= pending_d;
         tick_q         <= tick_d;
      end
   end

`ifdef DISP_BLINK_EN
   logic [3:0]         shadow_blink_q, shadow_blink_d;
   logic [3:0]         mask_q, mask_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               phase_q, phase_d;
   logic [3:0]         les_q, les_d;

   always_comb begin
      shadow_blink_d = shadow_blink_q;
      mask_d         = mask_q;
      blink_cnt_d    = blink_cnt_q;
      phase_d        = phase_q;

      if (frame_edge) begin
         if (load) begin
            mask_d = blink_in;
         end else if (pending_q) begin
            mask_d = shadow_blink_q;
         end
         blink_cnt_d = blink_cnt_q + 1'b1;
         if (&blink_cnt_q) begin
            phase_d = ~phase_q;
         end
      end else if (load) begin
         shadow_blink_d = blink_in;
      end

      // Built from next-state values so LES changes on the same edge as the mask and phase.
      les_d = ~(mask_d & {4{phase_d}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_blink_q <= '0;
         mask_q         <= '0;
         blink_cnt_q    <= '0;
         phase_q        <= 1'b0;
         les_q          <= 4'b1111;
      end else begin
         shadow_blink_q <= shadow_blink_d;
         mask_q         <= mask_d;
         blink_cnt_q    <= blink_cnt_d;
         phase_q        <= phase_d;
         les_q          <= les_d;
      end
   end

   assign LES = les_q;
`else
   logic unused_blink;
   assign unused_blink = ^{blink_in, BLINK_W[0]};
   assign LES          = 4'b1111;
`endif

   assign Scan       = scan_q;
   assign Hexs       = hexs_q;
   assign point      = point_q;
   assign pending    = pending_q;
   assign frame_tick = tick_q;

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16: prescaler width; one digit slot lasts 2^DIV_W clk cycles.
REQ-002 The block SHALL have parameter BLINK_W, default 5: blink phase toggles every 2^BLINK_W frames.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port load, input, 1 bit: single-cycle strobe; capture hex_in, point_in and blink_in.
REQ-006 The block SHALL have port hex_in, input, 16 bits: four 4-bit digit codes; digit 0 is at [3:0].
REQ-007 The block SHALL have port point_in, input, 4 bits: per-digit decimal-point value.
REQ-008 The block SHALL have port blink_in, input, 4 bits: per-digit blink mask; 1 means the digit blinks.
REQ-009 The block SHALL have port Scan, output, 2 bits: active digit index for the downstream scan mux.
REQ-010 The block SHALL have port Hexs, output, 16 bits: displayed digit codes.
REQ-011 The block SHALL have port point, output, 4 bits: displayed decimal points.
REQ-012 The block SHALL have port LES, output, 4 bits: per-digit enable; 1 means the digit is lit.
REQ-013 The block SHALL have port pending, output, 1 bit: high while loaded data is not yet displayed.
REQ-014 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame start.

Function
REQ-015 A DIV_W-bit prescaler SHALL increment every cycle, wrap from all-ones to 0, and assert internal slot_end while it is all-ones.
REQ-016 Scan SHALL increment on every clock edge with slot_end, wrapping 3->0, so each Scan value is held for exactly 2^DIV_W cycles.
REQ-017 A frame boundary SHALL be the edge on which slot_end=1 and Scan=3; Scan becomes 0 on that edge.
REQ-018 load=1 SHALL write hex_in, point_in and blink_in into a shadow buffer and set pending=1 on the next edge; Hexs, point and the mask SHALL NOT change outside a frame boundary.
REQ-019 A load while pending=1 SHALL overwrite the shadow buffer, keeping only the last loaded values, with pending remaining 1.
REQ-020 On a frame boundary with pending=1, Hexs, point and the active mask SHALL take the shadow values and pending SHALL clear, on the same edge Scan becomes 0.
REQ-021 If load=1 coincides with a frame boundary, hex_in, point_in and blink_in SHALL commit directly to the outputs on that edge, and pending SHALL be 0 afterwards.
REQ-022 frame_tick SHALL be registered and high for exactly the one cycle following each frame-boundary edge.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-024 While rst=1, asynchronously: Scan=0, prescaler=0, Hexs=16'h0000, point=4'b0000, LES=4'b1111, pending=0, frame_tick=0, shadow buffer=0, active mask=0, blink counter=0, blink phase=0.
REQ-025 rst asserted mid-frame SHALL discard any pending data; after release the prescaler SHALL restart from 0, with the first slot_end occurring 2^DIV_W-1 cycles after the first post-reset edge.

Configuration
REQ-026 With macro DISP_BLINK_EN defined, a BLINK_W-bit frame counter SHALL increment on each frame boundary, the blink phase SHALL toggle when the counter wraps, and LES[i] SHALL equal NOT(active_mask[i] AND phase), registered.
REQ-027 With DISP_BLINK_EN undefined, the blink counter and phase logic SHALL be absent, blink_in SHALL be ignored, and LES SHALL be constant 4'b1111.

Verification (DIV_W=2, BLINK_W=1 for simulation)
REQ-028 Scan sequence: release rst, no load -> Scan steps 0,1,2,3,0 holding each value for 4 cycles; frame_tick is high for exactly 1 cycle every 16 cycles; Hexs=0; LES=4'b1111.
REQ-029 Deferred commit: load hex_in=16'h1234 while Scan=1 -> pending=1, Hexs stays 0 until the frame boundary; then Hexs=16'h1234 and pending=0 in the same cycle Scan=0.
REQ-030 Overwrite and coincidence: load 16'hAAAA then 16'h5555 in the same frame -> only 16'h5555 is displayed; a load of 16'hBEEF on the boundary edge -> Hexs=16'hBEEF and pending=0 on that edge.
REQ-031 Blink (DISP_BLINK_EN defined): blink_in=4'b0101 committed -> LES alternates 4'b1111 and 4'b1010 every 2 frames; with the macro undefined, LES stays 4'b1111.
REQ-032 Async reset: assert rst mid-slot with pending=1 -> outputs reach their reset values without a clock edge; after release, pending=0 and the previous shadow data is never displayed.
